// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the counter
// sequencing controller and its tick generator.
package cnt_ctrl_pkg;

  localparam int DIV_SEL_W  = 2;
  localparam int PRESCALE_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Prescaler bits that must all be ones for a tick.
  function automatic logic [PRESCALE_W-1:0] div_mask(
    input logic [DIV_SEL_W-1:0] sel
  );
    logic [PRESCALE_W-1:0] m;
    m = '0;
    unique case (sel)
      2'd0: m = 3'b000;
      2'd1: m = 3'b001;
      2'd2: m = 3'b011;
      2'd3: m = 3'b111;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cnt_tick_gen.sv
// Free-running 3-bit prescaler with a decoded
// tick at f/2^div_sel while enabled.
module cnt_tick_gen
  import cnt_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DIV_SEL_W-1:0] div_sel,
  output logic                 tick
);

  logic [PRESCALE_W-1:0] pre;
  logic [PRESCALE_W-1:0] mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (clear) begin
      pre <= '0;
    end else if (enable) begin
      pre <= pre + PRESCALE_W'(1);
    end
  end

  assign mask = div_mask(div_sel);
  assign tick = enable && ((pre & mask) == mask);

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Start/stop/ack sequencing controller driving a
// prescaled WIDTH-bit counter with tc and done.
module cnt_seq_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [DIV_SEL_W-1:0] div_sel,
  input  logic [WIDTH-1:0]     limit,
  input  logic                 stop,
  input  logic                 ack,
  output logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic                 tc,
  output logic                 done
);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]     limit_r;
  logic                 mode_r;
  logic [DIV_SEL_W-1:0] div_r;
  logic                 tick;
  logic                 wrap;

  cnt_tick_gen u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == IDLE),
    .enable  (state == RUN),
    .div_sel (div_r),
    .tick    (tick)
  );

  assign wrap = tick && (q == limit_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (wrap && !mode_r) begin
          state_nxt = DONE;
        end
      end
      DONE: if (ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // stop wins over a coincident terminal tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      tc      <= 1'b0;
      limit_r <= '0;
      mode_r  <= 1'b0;
      div_r   <= '0;
    end else begin
      tc <= 1'b0;
      unique case (state)
        IDLE: begin
          q <= '0;
          if (start) begin
            limit_r <= limit;
            mode_r  <= mode;
            div_r   <= div_sel;
          end
        end
        RUN: begin
          if (stop) begin
            q <= '0;
          end else if (wrap) begin
            q  <= '0;
            tc <= 1'b1;
          end else if (tick) begin
            q <= q + WIDTH'(1);
          end
        end
        DONE: q <= '0;
        default: q <= '0;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: doc/cnt_seq_ctrl.md
# cnt_seq_ctrl

Sequencing controller for the team's small binary counters. It accepts a start request and captures a terminal count, a prescale select and a one-shot/periodic mode. It then drives a WIDTH-bit synchronous count at f/1, f/2, f/4 or f/8 of the clock and reports terminal count and completion through a done/ack handshake. It replaces free-running ripple counters wherever a counter must be started, stopped and observed under control of other logic.

## Interface
- WIDTH, 3: count width; q and limit are WIDTH bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  start request; sampled only in IDLE.
- mode  in  1  0 = one-shot, 1 = periodic; captured on start.
- div_sel  in  2  tick rate f/2^div_sel (0..3); captured on start.
- limit  in  WIDTH  terminal count, unsigned; captured on start.
- stop  in  1  abort; effective only in RUN.
- ack  in  1  completion acknowledge; effective only in DONE.
- q  out  WIDTH  current count.
- busy  out  1  high in RUN.
- tc  out  1  one-cycle pulse when the count wraps from limit.
- done  out  1  high in DONE.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, q=0, busy=0, tc=0, done=0, prescaler=0, captured config=0.
- IDLE to RUN:
  - Triggered by start=1.
  - Captures limit, mode and div_sel into registers; later input changes are ignored until the next start.
  - Clears q and the prescaler.
- Prescaler:
  - 3-bit counter that increments every RUN cycle and wraps.
  - tick=1 when the low div_sel bits of the prescaler are all ones; div_sel=0 gives a tick every cycle.
- RUN, on tick with q≠limit_r: q ← q+1.
- RUN, on tick with q=limit_r:
  - q ← 0 and tc pulses.
  - Periodic mode stays in RUN.
  - One-shot mode goes to DONE.
- limit=0: every tick is a terminal count.
- RUN with stop=1: go to IDLE, q ← 0, no tc pulse. stop has priority over a coincident tick.
- DONE:
  - q holds 0.
  - ack=1 returns to IDLE.
  - start and stop are ignored.
- start in RUN or DONE is ignored; there is no restart without stop or ack.
- Arithmetic: unsigned, modulo 2^WIDTH. q never exceeds limit_r.
- Asynchronous reset mid-operation forces all reset values immediately. The captured config is lost.

## Timing
- All outputs are registered.
- start sampled at edge n:
  - busy=1 and q=0 from edge n.
  - The first tick is evaluated in the cycle after edge n.
- div_sel=0:
  - q advances every clock.
  - tc period is (limit+1) clocks.
- General tc period: (limit+1)·2^div_sel clocks.
- tc is high for exactly one clock, in the same cycle q shows 0 after the wrap.
- One-shot:
  - done rises at the same edge as tc.
  - busy falls at that edge.
- ack sampled at edge m: done=0 from edge m. A start at edge m+1 is accepted.
- stop sampled at edge s: busy=0 and q=0 from edge s.

## Structure
- Shared package cnt_ctrl_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the DIV_SEL_W=2 constant;
  - the PRESCALE_W=3 constant.
- One sub-module, cnt_tick_gen:
  - prescaler plus tick decode;
  - inputs: clk, rst_n, clear, enable, div_sel;
  - output: tick.
- The FSM, capture registers and q counter live in cnt_seq_ctrl.

## Test plan
- Reset mid-RUN:
  - Stimulus: periodic, limit=5, div_sel=1; assert rst_n=0 asynchronously while q=3.
  - Response: q=0, busy=0, tc=0 and done=0 immediately. The controller stays idle until the next start.
- Periodic, no prescale:
  - Stimulus: limit=3, div_sel=0.
  - Response: q runs 0,1,2,3,0,… and tc pulses every 4 clocks; busy stays 1.
- One-shot with prescale:
  - Stimulus: limit=2, div_sel=3.
  - Response: done rises 24 clocks after start; tc pulses once, coincident with done; q=0. ack returns to IDLE, with done=0 the next cycle.
- Stop priority:
  - Stimulus: periodic, limit=1; assert stop in the same cycle as a tick with q=1.
  - Response: no tc, q=0, busy=0. A start during DONE of a later one-shot is ignored.
- limit=0 and reconfiguration:
  - Stimulus: div_sel=2; change limit and div_sel on the inputs mid-RUN.
  - Response: tc pulses every 4 clocks, and the mid-RUN input changes have no effect.
